pc_source_seq: RTL and testbench
================================

Name: pc_source_seq

Overview:
- Parametrised successor to the PC-source multiplexer.
- Selects the next program counter from NUM_SRC candidate buses and holds it in an internal PC register.
- Gates updates by pc_write, or by pc_write_cond with the branch condition.
- Adds exception entry with EPC capture, return via eret, and a sticky flag for out-of-range selects.
- Sits between the ALU/ALUOut/jump-address datapath and the instruction-fetch address port of the multicycle CPU.

Parameters:
- DATA_W, 32, width of the PC and of each source.
- NUM_SRC, 4, number of candidate sources (2..16); index 0 is lowest in src_bus.
- RESET_VEC, 32'h0000_0000, PC value after reset.
- EXC_BASE, 32'h0000_00FC, PC loaded on exception entry is EXC_BASE + exc_code.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- src_bus  in  NUM_SRC*DATA_W  concatenated sources; source i = src_bus[i*DATA_W +: DATA_W].
- pc_source  in  SEL_W  source select; SEL_W = max(1, clog2(NUM_SRC)).
- pc_write  in  1  unconditional PC update.
- pc_write_cond  in  1  conditional PC update (branch).
- zero  in  1  ALU zero flag.
- br_ne  in  1  0: take when zero=1 (beq); 1: take when zero=0 (bne).
- exc_req  in  1  exception request, sampled each cycle.
- exc_code  in  2  exception cause.
- eret  in  1  return from exception.
- pc  out  DATA_W  registered PC.
- pc_next  out  DATA_W  combinational selected source (0 when select is out of range).
- epc  out  DATA_W  saved PC of the last accepted exception.
- in_exc  out  1  high while in handler state.
- sel_err  out  1  sticky: an out-of-range select was used on an update.

Behaviour:
- Reset (reset=0 at a rising edge): pc=RESET_VEC, epc=0, in_exc=0, sel_err=0, state=RUN. Reset overrides every other input.
- Update condition: upd = pc_write | (pc_write_cond & (zero ^ br_ne)).
- FSM states:
  - RUN, the only state that accepts exceptions.
  - EXC, the handler state; further exc_req are ignored (masked, not queued).
- Priority per edge, RUN state:
  - 1) exc_req: epc<=pc, pc<=EXC_BASE+{exc_code}, go to EXC. upd in the same cycle is discarded.
  - 2) upd: pc<=pc_next.
  - 3) otherwise pc holds.
  - eret in RUN is ignored.
- Priority per edge, EXC state:
  - 1) eret: pc<=epc, go to RUN. upd in the same cycle is discarded.
  - 2) upd: pc<=pc_next (the handler runs normally).
  - 3) hold.
- in_exc = (state==EXC), registered.
- Latency: the new pc is visible one cycle after the qualifying edge. pc_next is purely combinational with zero latency.
- Out-of-range select (pc_source >= NUM_SRC):
  - pc_next=0.
  - If upd is also high, pc holds (no load) and sel_err<=1.
  - sel_err clears only on reset.
  - No select value ever infers a latch.
- pc_write and pc_write_cond both high: taken if either qualifies; single load.
- EXC_BASE+exc_code is computed modulo 2^DATA_W; wrap is allowed.
- Reset asserted mid-exception: returns to RUN, epc cleared.

Optional Feature:
- Macro: PC_SOURCE_BRCNT_EN.
- When defined:
  - Adds output br_taken_cnt, 16 bits, reset 0.
  - Increments on each edge in which pc_write_cond & (zero^br_ne) causes a load.
  - Saturates at 16'hFFFF; does not wrap.
  - Not counted when the load is discarded by exception or eret priority, or blocked by sel_err.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pc_source_pkg holds:
  - FSM state encoding: ST_RUN=1'b0, ST_EXC=1'b1.
  - Exception code constants: EXC_OPCODE=2'd0, EXC_OVF=2'd1, EXC_DIV0=2'd2.
  - A function computing SEL_W from NUM_SRC.
- One sub-module is natural: pc_src_mux. It is the parametrised combinational NUM_SRC:1 selector producing pc_next plus a sel_valid flag.

Test Plan:
- Reset and plain jump: reset=0 for 2 cycles → pc=0. Then src2=32'h0000_0040, pc_source=2, pc_write=1 for 1 cycle → pc=32'h40 on the next cycle and holds afterwards.
- Branch polarity: pc_write_cond=1, src1=32'h80.
  - zero=1, br_ne=0 → pc=32'h80.
  - zero=1, br_ne=1 → pc unchanged.
  - zero=0, br_ne=1 → pc=32'h80.
- Exception entry and return: pc=32'h100, exc_req=1, exc_code=1, pc_write=1 → epc=32'h100, pc=32'hFD, in_exc=1. A second exc_req is ignored. eret=1 → pc=32'h100, in_exc=0.
- Out-of-range select with NUM_SRC=3: pc_source=3, pc_write=1 → pc_next=0, pc holds, sel_err=1. sel_err stays 1 after valid loads until reset.
- Reset mid-exception: while in_exc=1, drive reset=0 → pc=RESET_VEC, epc=0, in_exc=0 on the next edge.
- With PC_SOURCE_BRCNT_EN: 3 taken branches, 1 not taken, and 1 taken branch coinciding with exc_req → br_taken_cnt=3. Preload near 16'hFFFF → count saturates.

Source files
------------

// File: rtl/pc_source_pkg.sv
// rtl/pc_source_pkg.sv - shared types and constants for the PC source sequencer (PC_SOURCE_BRCNT_EN)
package pc_source_pkg;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_EXC = 1'b1
   } pc_state_e;

   localparam logic [1:0] EXC_OPCODE = 2'd0;
   localparam logic [1:0] EXC_OVF    = 2'd1;
   localparam logic [1:0] EXC_DIV0   = 2'd2;

   // Select width never drops below one bit, even for tiny source counts.
   function automatic int sel_w_f(input int num_src);
      return (num_src <= 2) ? 1 : $clog2(num_src);
   endfunction

endpackage

// File: rtl/pc_src_mux.sv
// rtl/pc_src_mux.sv - combinational NUM_SRC:1 selector with select-range flag
module pc_src_mux #(
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 2
) (
   input  logic [NUM_SRC*DATA_W-1:0] src_bus_i,
   input  logic [SEL_W-1:0]          sel_i,
   output logic [DATA_W-1:0]         data_o,
   output logic                      sel_valid_o
);

   // Unmatched selects fall through to zero, so no value can hold a latch.
   always_comb begin
      data_o = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel_i == SEL_W'(i)) begin
            data_o = src_bus_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign sel_valid_o = (int'(sel_i) < NUM_SRC);

endmodule

// File: rtl/pc_source_seq.sv
// rtl/pc_source_seq.sv - PC register with source select, branch gating, exceptions; PC_SOURCE_BRCNT_EN adds a branch counter
module pc_source_seq
   import pc_source_pkg::*;
#(
   parameter int                  DATA_W    = 32,
   parameter int                  NUM_SRC   = 4,
   parameter logic [DATA_W-1:0]   RESET_VEC = '0,
   parameter logic [DATA_W-1:0]   EXC_BASE  = DATA_W'(32'h0000_00FC),
   localparam int                 SEL_W     = sel_w_f(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC*DATA_W-1:0] src_bus,
   input  logic [SEL_W-1:0]          pc_source,
   input  logic                      pc_write,
   input  logic                      pc_write_cond,
   input  logic                      zero,
   input  logic                      br_ne,
   input  logic                      exc_req,
   input  logic [1:0]                exc_code,
   input  logic                      eret,
   output logic [DATA_W-1:0]         pc,
   output logic [DATA_W-1:0]         pc_next,
   output logic [DATA_W-1:0]         epc,
`ifdef PC_SOURCE_BRCNT_EN
   output logic [15:0]               br_taken_cnt,
`endif
   output logic                      in_exc,
   output logic                      sel_err
);

   pc_state_e         state_q;
   logic [DATA_W-1:0] pc_q;
   logic [DATA_W-1:0] epc_q;
   logic              sel_err_q;
   logic              sel_valid;
   logic              br_take;
   logic              upd;

   pc_src_mux #(
      .DATA_W  (DATA_W),
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_mux (
      .src_bus_i   (src_bus),
      .sel_i       (pc_source),
      .data_o      (pc_next),
      .sel_valid_o (sel_valid)
   );

   assign br_take = pc_write_cond & (zero ^ br_ne);
   assign upd     = pc_write | br_take;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_RUN;
         pc_q      <= RESET_VEC;
         epc_q     <= '0;
         sel_err_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (exc_req) begin
                  epc_q   <= pc_q;
                  pc_q    <= EXC_BASE + DATA_W'(exc_code);
                  state_q <= ST_EXC;
               end else if (upd) begin
                  if (sel_valid) pc_q <= pc_next;
                  else           sel_err_q <= 1'b1;
               end
            end
            ST_EXC: begin
               // Exceptions raised inside the handler are dropped, not queued.
               if (eret) begin
                  pc_q    <= epc_q;
                  state_q <= ST_RUN;
               end else if (upd) begin
                  if (sel_valid) pc_q <= pc_next;
                  else           sel_err_q <= 1'b1;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign pc      = pc_q;
   assign epc     = epc_q;
   assign in_exc  = (state_q == ST_EXC);
   assign sel_err = sel_err_q;

`ifdef PC_SOURCE_BRCNT_EN
   logic [15:0] cnt_q;
   logic        br_load;

   // A branch only counts when it actually reaches the PC register.
   assign br_load = br_take & sel_valid &
                    ((state_q == ST_RUN) ? ~exc_req : ~eret);

   always_ff @(posedge clk) begin
      if (!reset)                          cnt_q <= '0;
      else if (br_load && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
   end

   assign br_taken_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_source_seq.sv
// tb/tb_pc_source_seq.sv - self-checking bench for pc_source_seq (PC_SOURCE_BRCNT_EN aware)
module tb_pc_source_seq;

   localparam int NSRC = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] src [NSRC];
   logic [1:0]  pc_source;
   logic        pc_write, pc_write_cond, zero, br_ne, exc_req, eret;
   logic [1:0]  exc_code;
   logic [31:0] pc, pc_next, epc;
   logic        in_exc, sel_err;
   logic [15:0] cnt_obs;

   int total = 0;
   int bad   = 0;

   // reference state
   logic [31:0] m_pc, m_epc;
   logic        m_handler, m_serr;
   int          m_cnt;

   always #5 clk = ~clk;

`ifdef PC_SOURCE_BRCNT_EN
   logic [15:0] br_taken_cnt;
   assign cnt_obs = br_taken_cnt;
`else
   assign cnt_obs = 16'd0;
`endif

   pc_source_seq #(.DATA_W(32), .NUM_SRC(NSRC)) dut (
      .clk           (clk),
      .reset         (reset),
      .src_bus       ({src[2], src[1], src[0]}),
      .pc_source     (pc_source),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .zero          (zero),
      .br_ne         (br_ne),
      .exc_req       (exc_req),
      .exc_code      (exc_code),
      .eret          (eret),
      .pc            (pc),
      .pc_next       (pc_next),
      .epc           (epc),
`ifdef PC_SOURCE_BRCNT_EN
      .br_taken_cnt  (br_taken_cnt),
`endif
      .in_exc        (in_exc),
      .sel_err       (sel_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      reset = 1'b1; pc_write = 0; pc_write_cond = 0; zero = 0; br_ne = 0;
      exc_req = 0; eret = 0; exc_code = 0; pc_source = 0;
   endtask

   // One clock: check combinational select, advance model on the edge, check registers.
   task automatic cycle();
      logic [31:0] exp_next;
      logic        branch, take;
      #1;
      exp_next = (int'(pc_source) < NSRC) ? src[int'(pc_source)] : 32'd0;
      check("pc_next", pc_next, exp_next);
      @(posedge clk);
      branch = pc_write_cond && (zero != br_ne);
      take   = pc_write || branch;
      if (!reset) begin
         m_pc = 0; m_epc = 0; m_handler = 0; m_serr = 0; m_cnt = 0;
      end else if (!m_handler && exc_req) begin
         m_epc = m_pc; m_pc = 32'hFC + exc_code; m_handler = 1;
      end else if (m_handler && eret) begin
         m_pc = m_epc; m_handler = 0;
      end else if (take) begin
         if (int'(pc_source) < NSRC) begin
            m_pc = exp_next;
            if (branch && m_cnt < 65535) m_cnt++;
         end else m_serr = 1;
      end
      #1;
      check("pc", pc, m_pc);
      check("epc", epc, m_epc);
      check("in_exc", in_exc, m_handler);
      check("sel_err", sel_err, m_serr);
`ifdef PC_SOURCE_BRCNT_EN
      check("br_cnt", cnt_obs, m_cnt);
`endif
   endtask

   task automatic jump(input logic [31:0] target);
      idle(); src[2] = target; pc_source = 2; pc_write = 1; cycle();
   endtask

   initial begin
      for (int i = 0; i < NSRC; i++) src[i] = 0;
      m_pc = 0; m_epc = 0; m_handler = 0; m_serr = 0; m_cnt = 0;
      idle(); reset = 0;
      cycle(); cycle();
      check("reset_pc", pc, 32'h0);
      check("reset_in_exc", in_exc, 1'b0);

      jump(32'h40);
      check("jump_pc", pc, 32'h40);
      idle(); cycle();
      check("jump_hold", pc, 32'h40);

      idle(); src[1] = 32'h80; pc_source = 1; pc_write_cond = 1; zero = 1; br_ne = 0; cycle();
      check("beq_taken", pc, 32'h80);
      jump(32'h40);
      idle(); src[1] = 32'h80; pc_source = 1; pc_write_cond = 1; zero = 1; br_ne = 1; cycle();
      check("bne_not_taken", pc, 32'h40);
      idle(); src[1] = 32'h80; pc_source = 1; pc_write_cond = 1; zero = 0; br_ne = 1; cycle();
      check("bne_taken", pc, 32'h80);

      jump(32'h100);
      idle(); exc_req = 1; exc_code = 1; pc_write = 1; pc_source = 2; cycle();
      check("exc_epc", epc, 32'h100);
      check("exc_pc", pc, 32'hFD);
      check("exc_in", in_exc, 1'b1);
      idle(); exc_req = 1; exc_code = 2; cycle();
      check("exc_masked_pc", pc, 32'hFD);
      check("exc_masked_epc", epc, 32'h100);
      idle(); eret = 1; cycle();
      check("eret_pc", pc, 32'h100);
      check("eret_in", in_exc, 1'b0);

      idle(); pc_source = 3; pc_write = 1; #1;
      check("oor_next", pc_next, 32'h0);
      cycle();
      check("oor_hold", pc, 32'h100);
      check("oor_err", sel_err, 1'b1);
      jump(32'h40);
      check("err_sticky", sel_err, 1'b1);

      idle(); exc_req = 1; cycle();
      idle(); reset = 0; cycle();
      check("rst_exc_pc", pc, 32'h0);
      check("rst_exc_epc", epc, 32'h0);
      check("rst_exc_in", in_exc, 1'b0);
      check("rst_exc_err", sel_err, 1'b0);

`ifdef PC_SOURCE_BRCNT_EN
      for (int i = 0; i < 3; i++) begin
         idle(); src[0] = 32'h10 * (i + 1); pc_write_cond = 1; zero = 1; cycle();
      end
      idle(); pc_write_cond = 1; zero = 0; cycle();
      idle(); pc_write_cond = 1; zero = 1; exc_req = 1; cycle();
      check("cnt_three", cnt_obs, 16'd3);
      idle(); eret = 1; cycle();
      for (int i = 0; i < 65540; i++) begin
         idle(); pc_write_cond = 1; zero = 1; cycle();
      end
      check("cnt_sat", cnt_obs, 16'hFFFF);
      idle(); reset = 0; cycle();
`endif

      for (int n = 0; n < 600; n++) begin
         idle();
         for (int i = 0; i < NSRC; i++) src[i] = $urandom;
         reset         = ($urandom_range(0, 39) != 0);
         pc_source     = 2'($urandom_range(0, 3));
         pc_write      = ($urandom_range(0, 3) == 0);
         pc_write_cond = ($urandom_range(0, 2) == 0);
         zero          = 1'($urandom);
         br_ne         = 1'($urandom);
         exc_req       = ($urandom_range(0, 7) == 0);
         exc_code      = 2'($urandom);
         eret          = ($urandom_range(0, 5) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
